fft_sdf_ctrl: RTL and testbench

- Sequencer for a radix-2 single-path delay-feedback (SDF) FFT pipeline of LOG_N stages.
- Stage s uses a delay line of N>>(s+1) samples plus a butterfly with BF_LAT register stages.
- The block owns the global sample counter and generates the pipeline advance enable, per-stage butterfly/switch selects and per-stage twiddle addresses.
- It tracks pipeline fill, frames the output with valid/start-of-frame, and drains the pipeline with zero insertion on flush.

---
 rtl/fft_pkg.sv | 36 +++
 rtl/fft_stage_sel.sv | 31 +++
 rtl/fft_sdf_ctrl.sv | 116 +++++++++++
 tb/tb_fft_sdf_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constant helpers for the radix-2 SDF FFT controller.
// Stage geometry is derived here so the top and per-stage logic agree.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN
    } state_t;

    function automatic int fft_n(input int log_n);
        return 1 << log_n;
    endfunction

    function automatic int stage_dly(input int log_n, input int s);
        return fft_n(log_n) >> (s + 1);
    endfunction

    function automatic int stage_off(input int log_n, input int bf_lat,
                                     input int s);
        int off;
        off = 0;
        for (int j = 0; j < s; j++) off += stage_dly(log_n, j);
        return off + s * bf_lat;
    endfunction

    function automatic int total_lat(input int log_n, input int bf_lat);
        return fft_n(log_n) - 1 + log_n * bf_lat;
    endfunction

    function automatic int tw_w(input int log_n);
        return log_n - 1;
    endfunction

endpackage

// File: rtl/fft_stage_sel.sv
// Per-stage butterfly select and twiddle address generation.
// The stage sees the input counter delayed by its cumulative latency.
module fft_stage_sel
    import fft_pkg::*;
#(
    parameter int LOG_N  = 6,
    parameter int BF_LAT = 1,
    parameter int S      = 0
) (
    input  logic [LOG_N-1:0]        cnt_eff,
    output logic                    bf_sel,
    output logic [tw_w(LOG_N)-1:0]  tw_addr
);

    localparam int TWW = tw_w(LOG_N);
    localparam int OFF = stage_off(LOG_N, BF_LAT, S);
    localparam int DLY = stage_dly(LOG_N, S);
    localparam logic [LOG_N-1:0] OFF_M = LOG_N'(OFF);
    localparam logic [LOG_N-1:0] MASK  = LOG_N'(DLY - 1);

    logic [LOG_N-1:0] cnt_s;

    // Align the counter to this stage, pick the phase bit, scale the twiddle
    always_comb begin
        cnt_s   = cnt_eff - OFF_M;
        bf_sel  = cnt_s[LOG_N-1-S];
        tw_addr = TWW'((cnt_s & MASK) << S);
        if (bf_sel) tw_addr = '0;
    end

endmodule

// File: rtl/fft_sdf_ctrl.sv
// Sequencer for a radix-2 SDF FFT pipeline: advance, selects, twiddles,
// fill tracking, output framing and zero-insertion drain.
module fft_sdf_ctrl
    import fft_pkg::*;
#(
    parameter int LOG_N  = 6,
    parameter int BF_LAT = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic                         flush,
    output logic                         in_ready,
    output logic                         adv,
    output logic                         zero_ins,
    output logic [LOG_N-1:0]             bf_sel,
    output logic [LOG_N*(LOG_N-1)-1:0]   tw_addr,
    output logic                         out_valid,
    output logic                         out_sof,
    output logic                         sync_err,
    output logic                         busy
);

    localparam int TWW = tw_w(LOG_N);
    localparam int TL  = total_lat(LOG_N, BF_LAT);
    localparam int FW  = $clog2(TL + 1);
    localparam logic [FW-1:0]    TL_F  = FW'(TL);
    localparam logic [FW-1:0]    TL_F1 = FW'(TL - 1);
    localparam logic [LOG_N-1:0] TL_M  = LOG_N'(TL);

    state_t                  state, state_nxt;
    logic [LOG_N-1:0]        cnt, cnt_eff, out_idx;
    logic [FW-1:0]           fill, fill_nxt, f_lat, drain_cnt;
    logic                    act, sof_hit, sof_bad, sel_en;
    logic [LOG_N-1:0]        sel_raw;
    logic [LOG_N*TWW-1:0]    tw_raw;

    for (genvar s = 0; s < LOG_N; s++) begin : g_stage
        fft_stage_sel #(
            .LOG_N  (LOG_N),
            .BF_LAT (BF_LAT),
            .S      (s)
        ) u_sel (
            .cnt_eff (cnt_eff),
            .bf_sel  (sel_raw[s]),
            .tw_addr (tw_raw[s*TWW +: TWW])
        );
    end

    // Next state, fill accounting and all control outputs
    always_comb begin
        act       = (state == FILL) || (state == RUN);
        sof_hit   = in_valid && in_sof && (state != DRAIN);
        cnt_eff   = sof_hit ? '0 : cnt;
        sof_bad   = act && in_valid && in_sof && (cnt != '0);
        adv       = (state == DRAIN) ? 1'b1 : in_valid;
        zero_ins  = (state == DRAIN);
        in_ready  = (state != DRAIN);
        busy      = (state != IDLE);
        sync_err  = sof_bad;
        out_idx   = cnt_eff - TL_M;
        sel_en    = (state != IDLE) || in_valid;
        bf_sel    = sel_en ? sel_raw : '0;
        tw_addr   = sel_en ? tw_raw : '0;
        state_nxt = state;
        fill_nxt  = fill;
        out_valid = 1'b0;
        // A realigning sof restarts the fill, and its own sample counts
        if (state != DRAIN && adv) begin
            if (sof_bad) fill_nxt = FW'(1);
            else if (fill != TL_F) fill_nxt = fill + 1'b1;
        end
        unique case (state)
            IDLE: begin
                if (in_valid) state_nxt = FILL;
            end
            FILL: begin
                if (flush && fill_nxt != '0) state_nxt = DRAIN;
                else if (!sof_bad && fill_nxt == TL_F) state_nxt = RUN;
            end
            RUN: begin
                out_valid = adv && (fill == TL_F) && !sof_bad;
                if (flush && fill_nxt != '0) state_nxt = DRAIN;
                else if (sof_bad) state_nxt = FILL;
            end
            DRAIN: begin
                out_valid = (drain_cnt >= TL_F - f_lat);
                if (drain_cnt == TL_F1) state_nxt = IDLE;
            end
        endcase
        out_sof = out_valid && (out_idx == '0);
    end

    // State, sample counter, fill and drain bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            fill      <= '0;
            f_lat     <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (adv) cnt <= cnt_eff + 1'b1;
            fill <= (state_nxt == IDLE) ? '0 : fill_nxt;
            if (state != DRAIN && state_nxt == DRAIN) begin
                f_lat     <= fill_nxt;
                drain_cnt <= '0;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// Directed testbench for fft_sdf_ctrl at LOG_N=6, BF_LAT=1 (latency 69).
// Expected selects come from a closed-form stage offset 64-(64>>s)+s.
module tb_fft_sdf_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_sof;
    logic        flush;
    logic        in_ready;
    logic        adv;
    logic        zero_ins;
    logic [5:0]  bf_sel;
    logic [29:0] tw_addr;
    logic        out_valid;
    logic        out_sof;
    logic        sync_err;
    logic        busy;

    int checks;
    int failures;

    fft_sdf_ctrl #(
        .LOG_N  (6),
        .BF_LAT (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .flush     (flush),
        .in_ready  (in_ready),
        .adv       (adv),
        .zero_ins  (zero_ins),
        .bf_sel    (bf_sel),
        .tw_addr   (tw_addr),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .sync_err  (sync_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [5:0] exp_bf(input int c);
        logic [5:0] r;
        logic [5:0] cs;
        int off;
        r = '0;
        for (int s = 0; s < 6; s++) begin
            off  = 64 - (64 >> s) + s;
            cs   = 6'((c - off + 128) % 64);
            r[s] = cs[5-s];
        end
        return r;
    endfunction

    function automatic logic [29:0] exp_tw(input int c);
        logic [29:0] r;
        logic [5:0] cs;
        int off;
        r = '0;
        for (int s = 0; s < 6; s++) begin
            off = 64 - (64 >> s) + s;
            cs  = 6'((c - off + 128) % 64);
            if (!cs[5-s]) r[s*5 +: 5] = 5'((int'(cs) % (64 >> (s + 1))) << s);
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic s, input logic f);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        flush    = f;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] fl;
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        #1;
        fl = {in_ready, adv, zero_ins, out_valid, out_sof, sync_err, busy};
        checks++;
        if (fl !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_flags got %b exp 1000000", fl);
        end
        checks++;
        if (bf_sel !== 6'd0) begin
            failures++;
            $display("FAIL reset_bf_sel got %h exp 0", bf_sel);
        end
        checks++;
        if (tw_addr !== 30'd0) begin
            failures++;
            $display("FAIL reset_tw_addr got %h exp 0", tw_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle_flush();
        do_reset();
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (in_ready !== 1'b1 || adv !== 1'b0) begin
            failures++;
            $display("FAIL idle_flush_cyc got rdy=%b adv=%b exp 1 0",
                     in_ready, adv);
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0 || zero_ins !== 1'b0) begin
            failures++;
            $display("FAIL idle_flush_after got busy=%b zi=%b exp 0 0",
                     busy, zero_ins);
        end
    endtask

    task automatic test_frames();
        do_reset();
        for (int k = 0; k < 192; k++) begin
            drive(1'b1, (k % 64) == 0, 1'b0);
            checks++;
            if (bf_sel !== exp_bf(k % 64)) begin
                failures++;
                $display("FAIL frames_bf k=%0d got %h exp %h",
                         k, bf_sel, exp_bf(k % 64));
            end
            checks++;
            if (tw_addr !== exp_tw(k % 64)) begin
                failures++;
                $display("FAIL frames_tw k=%0d got %h exp %h",
                         k, tw_addr, exp_tw(k % 64));
            end
            checks++;
            if (out_valid !== (k >= 69) || adv !== 1'b1) begin
                failures++;
                $display("FAIL frames_ov k=%0d got ov=%b adv=%b exp %b 1",
                         k, out_valid, adv, k >= 69);
            end
            checks++;
            if (out_sof !== (k >= 69 && (k - 69) % 64 == 0)) begin
                failures++;
                $display("FAIL frames_sof k=%0d got %b", k, out_sof);
            end
            checks++;
            if (busy !== (k != 0)) begin
                failures++;
                $display("FAIL frames_busy k=%0d got %b exp %b",
                         k, busy, k != 0);
            end
        end
    endtask

    task automatic test_gaps();
        int a;
        logic v;
        a = 0;
        do_reset();
        for (int c = 0; c < 160; c++) begin
            v = (c % 4 == 0) || (c % 4 == 3);
            drive(v, v && (a % 64 == 0), 1'b0);
            checks++;
            if (adv !== v) begin
                failures++;
                $display("FAIL gaps_adv c=%0d got %b exp %b", c, adv, v);
            end
            checks++;
            if (bf_sel !== exp_bf(a % 64) || tw_addr !== exp_tw(a % 64)) begin
                failures++;
                $display("FAIL gaps_sel c=%0d got %h/%h exp %h/%h", c,
                         bf_sel, tw_addr, exp_bf(a % 64), exp_tw(a % 64));
            end
            checks++;
            if (out_valid !== (v && a >= 69)) begin
                failures++;
                $display("FAIL gaps_ov c=%0d a=%0d got %b exp %b",
                         c, a, out_valid, v && a >= 69);
            end
            checks++;
            if (out_sof !== (v && a >= 69 && (a - 69) % 64 == 0)) begin
                failures++;
                $display("FAIL gaps_sof c=%0d a=%0d got %b", c, a, out_sof);
            end
            if (v) a++;
        end
    endtask

    task automatic test_flush_full();
        do_reset();
        for (int k = 0; k < 100; k++) drive(1'b1, (k % 64) == 0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ffull_pre got ov=%b exp 1", out_valid);
        end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (adv !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ffull_req got adv=%b ov=%b busy=%b exp 0 0 1",
                     adv, out_valid, busy);
        end
        for (int d = 0; d < 69; d++) begin
            drive(1'b1, 1'b1, d == 5);
            checks++;
            if ({adv, zero_ins, in_ready, out_valid, busy} !== 5'b11011) begin
                failures++;
                $display("FAIL ffull_drain d=%0d got %b exp 11011", d,
                         {adv, zero_ins, in_ready, out_valid, busy});
            end
            checks++;
            if (out_sof !== (d == 33) || sync_err !== 1'b0) begin
                failures++;
                $display("FAIL ffull_sof d=%0d got sof=%b se=%b exp %b 0",
                         d, out_sof, sync_err, d == 33);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, in_ready, adv, zero_ins, out_valid} !== 5'b01000) begin
            failures++;
            $display("FAIL ffull_idle got %b exp 01000",
                     {busy, in_ready, adv, zero_ins, out_valid});
        end
    endtask

    task automatic test_flush_short();
        do_reset();
        for (int k = 0; k < 9; k++) drive(1'b1, k == 0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        checks++;
        if (adv !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fshort_req got adv=%b ov=%b exp 1 0",
                     adv, out_valid);
        end
        for (int d = 0; d < 69; d++) begin
            drive(1'b0, 1'b0, 1'b0);
            checks++;
            if (out_valid !== (d >= 59)) begin
                failures++;
                $display("FAIL fshort_ov d=%0d got %b exp %b",
                         d, out_valid, d >= 59);
            end
            checks++;
            if (in_ready !== 1'b0 || zero_ins !== 1'b1 || adv !== 1'b1) begin
                failures++;
                $display("FAIL fshort_ctl d=%0d got rdy=%b zi=%b adv=%b",
                         d, in_ready, zero_ins, adv);
            end
            checks++;
            if (out_sof !== (d == 59)) begin
                failures++;
                $display("FAIL fshort_sof d=%0d got %b exp %b",
                         d, out_sof, d == 59);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL fshort_idle got busy=%b rdy=%b exp 0 1",
                     busy, in_ready);
        end
    endtask

    task automatic test_sync_err();
        do_reset();
        for (int k = 0; k < 104; k++) drive(1'b1, (k % 64) == 0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || sync_err !== 1'b0) begin
            failures++;
            $display("FAIL sync_pre got ov=%b se=%b exp 1 0",
                     out_valid, sync_err);
        end
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (sync_err !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sync_pulse got se=%b ov=%b exp 1 0",
                     sync_err, out_valid);
        end
        checks++;
        if (bf_sel !== exp_bf(0) || tw_addr !== exp_tw(0)) begin
            failures++;
            $display("FAIL sync_sel got %h/%h exp %h/%h",
                     bf_sel, tw_addr, exp_bf(0), exp_tw(0));
        end
        for (int j = 1; j < 76; j++) begin
            drive(1'b1, j == 64, 1'b0);
            checks++;
            if (sync_err !== 1'b0) begin
                failures++;
                $display("FAIL sync_quiet j=%0d got se=%b exp 0", j, sync_err);
            end
            checks++;
            if (bf_sel !== exp_bf(j % 64)) begin
                failures++;
                $display("FAIL sync_bf j=%0d got %h exp %h",
                         j, bf_sel, exp_bf(j % 64));
            end
            checks++;
            if (out_valid !== (j >= 69) || out_sof !== (j == 69)) begin
                failures++;
                $display("FAIL sync_ov j=%0d got ov=%b sof=%b exp %b %b",
                         j, out_valid, out_sof, j >= 69, j == 69);
            end
        end
    endtask

    task automatic test_reset_drain();
        logic [6:0] fl;
        do_reset();
        for (int k = 0; k < 20; k++) drive(1'b1, k == 0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        for (int d = 0; d < 10; d++) drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (zero_ins !== 1'b1) begin
            failures++;
            $display("FAIL rdrain_pre got zi=%b exp 1", zero_ins);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        fl = {in_ready, adv, zero_ins, out_valid, out_sof, sync_err, busy};
        checks++;
        if (fl !== 7'b1000000) begin
            failures++;
            $display("FAIL rdrain_flags got %b exp 1000000", fl);
        end
        checks++;
        if (bf_sel !== 6'd0 || tw_addr !== 30'd0) begin
            failures++;
            $display("FAIL rdrain_sel got %h/%h exp 0/0", bf_sel, tw_addr);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        flush    = 1'b0;
        test_reset();
        test_idle_flush();
        test_frames();
        test_gaps();
        test_flush_full();
        test_flush_short();
        test_sync_err();
        test_reset_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
